// File: rtl/screen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : screen_ctrl
// Purpose  : Menu/screen sequencer for a VGA front end. Debounces the two
//            active-low pushbuttons, steps between the title, instructions
//            and game screens, kicks the screen-memory drawer with a one-cycle
//            draw_go, and re-times the drawer's busy flag and coordinates into
//            the VGA plot strobe.
// Ports    : clk           - single clock, rising edge
//            resetn        - asynchronous active-low reset
//            key_next      - raw active-low "next" button (async)
//            key_back      - raw active-low "back" button (async)
//            draw_busy     - drawer is writing pixels
//            x_in, y_in    - drawer's current pixel coordinates
//            select_screen - 0 title, 1 instructions, 2 game
//            draw_go       - one-cycle start pulse for a full-screen draw
//            plot          - VGA write enable
//            x_out, y_out  - coordinates aligned with plot
//            game_active   - game screen owns the display
// Revision : 1.0 - initial release
// ============================================================================
module screen_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PLOT_DELAY      = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       key_next,
    input  logic       key_back,
    input  logic       draw_busy,
    input  logic [9:0] x_in,
    input  logic [9:0] y_in,
    output logic [1:0] select_screen,
    output logic       draw_go,
    output logic       plot,
    output logic [9:0] x_out,
    output logic [9:0] y_out,
    output logic       game_active
);

    // Debounce counter runs 0..DEBOUNCE_CYCLES-1 over consecutive samples
    // that disagree with the accepted level.
    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] S_LAUNCH     = 3'd0;
    localparam logic [2:0] S_WAIT_START = 3'd1;
    localparam logic [2:0] S_DRAWING    = 3'd2;
    localparam logic [2:0] S_SHOWN      = 3'd3;
    localparam logic [2:0] S_GAME       = 3'd4;

    localparam logic [1:0] c_SCR_TITLE = 2'd0;
    localparam logic [1:0] c_SCR_INSTR = 2'd1;
    localparam logic [1:0] c_SCR_GAME  = 2'd2;

    // ------------------------------------------------------------------
    // Key conditioning: bit 0 = next, bit 1 = back.
    // ------------------------------------------------------------------
    logic [1:0] w_key_raw;
    logic [1:0] w_press;

    assign w_key_raw = {key_back, key_next};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            logic               r_sync1;
            logic               r_sync2;
            logic               r_level;
            logic               r_press;
            logic [c_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_sync1 <= 1'b1;
                    r_sync2 <= 1'b1;
                    r_level <= 1'b1;
                    r_press <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_key_raw[gi];
                    r_sync2 <= r_sync1;
                    r_press <= 1'b0;
                    if (r_sync2 == r_level) begin
                        // Agreeing sample: any run of disagreement is broken.
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_MAX) begin
                        // Enough consecutive disagreeing samples: accept the
                        // new level; only a 1->0 change is a press.
                        r_cnt   <= '0;
                        r_level <= r_sync2;
                        r_press <= ~r_sync2;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    // Back dominates next when both fire together.
    logic w_back_ev;
    logic w_next_ev;

    assign w_back_ev = w_press[1];
    assign w_next_ev = w_press[0] & ~w_press[1];

    // ------------------------------------------------------------------
    // Single-entry pending slot merged with this cycle's live event.
    // A live event replaces the held one, except a held back survives a
    // live next. The merged result is what SHOWN acts on and what the
    // busy states store.
    // ------------------------------------------------------------------
    logic r_pend_vld;
    logic r_pend_back;
    logic w_slot_vld;
    logic w_slot_back;

    assign w_slot_vld  = w_back_ev | w_next_ev | r_pend_vld;
    assign w_slot_back = w_back_ev | (r_pend_vld & r_pend_back);

    // ------------------------------------------------------------------
    // Screen sequencer. All outputs are registered here.
    // ------------------------------------------------------------------
    logic [2:0] r_state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_LAUNCH;
            select_screen <= c_SCR_TITLE;
            game_active   <= 1'b0;
            draw_go       <= 1'b0;
            r_pend_vld    <= 1'b0;
            r_pend_back   <= 1'b0;
        end else begin
            draw_go <= 1'b0;
            case (r_state)
                S_LAUNCH: begin
                    draw_go     <= 1'b1;
                    r_state     <= S_WAIT_START;
                    r_pend_vld  <= w_slot_vld;
                    r_pend_back <= w_slot_back;
                end
                S_WAIT_START: begin
                    r_pend_vld  <= w_slot_vld;
                    r_pend_back <= w_slot_back;
                    if (draw_busy) begin
                        r_state <= S_DRAWING;
                    end
                end
                S_DRAWING: begin
                    r_pend_vld  <= w_slot_vld;
                    r_pend_back <= w_slot_back;
                    if (!draw_busy) begin
                        r_state <= S_SHOWN;
                    end
                end
                S_SHOWN: begin
                    r_pend_vld  <= 1'b0;
                    r_pend_back <= 1'b0;
                    if (w_slot_vld) begin
                        if (w_slot_back) begin
                            // Back on the title screen has nowhere to go.
                            if (select_screen == c_SCR_INSTR) begin
                                select_screen <= c_SCR_TITLE;
                                r_state       <= S_LAUNCH;
                            end
                        end else if (select_screen == c_SCR_TITLE) begin
                            select_screen <= c_SCR_INSTR;
                            r_state       <= S_LAUNCH;
                        end else if (select_screen == c_SCR_INSTR) begin
                            select_screen <= c_SCR_GAME;
                            game_active   <= 1'b1;
                            r_state       <= S_GAME;
                        end
                    end
                end
                S_GAME: begin
                    r_pend_vld  <= 1'b0;
                    r_pend_back <= 1'b0;
                    if (w_back_ev) begin
                        select_screen <= c_SCR_TITLE;
                        game_active   <= 1'b0;
                        r_state       <= S_LAUNCH;
                    end
                end
                default: begin
                    r_state <= S_LAUNCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Memory-read alignment pipeline: busy and coordinates travel
    // together so plot lines up with the colour coming out of memory.
    // Clearing it on reset kills any in-flight pixels of an aborted draw.
    // ------------------------------------------------------------------
    logic [PLOT_DELAY-1:0] r_busy_pipe;
    logic [9:0]            r_x_pipe [PLOT_DELAY];
    logic [9:0]            r_y_pipe [PLOT_DELAY];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy_pipe <= '0;
            for (int i = 0; i < PLOT_DELAY; i++) begin
                r_x_pipe[i] <= '0;
                r_y_pipe[i] <= '0;
            end
        end else begin
            r_busy_pipe[0] <= draw_busy;
            r_x_pipe[0]    <= x_in;
            r_y_pipe[0]    <= y_in;
            for (int i = 1; i < PLOT_DELAY; i++) begin
                r_busy_pipe[i] <= r_busy_pipe[i-1];
                r_x_pipe[i]    <= r_x_pipe[i-1];
                r_y_pipe[i]    <= r_y_pipe[i-1];
            end
        end
    end

    // The game logic owns the VGA port while game_active is set.
    assign plot  = r_busy_pipe[PLOT_DELAY-1] & ~game_active;
    assign x_out = r_x_pipe[PLOT_DELAY-1];
    assign y_out = r_y_pipe[PLOT_DELAY-1];

endmodule
`default_nettype wire

// File: tb/tb_screen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_screen_ctrl
// Purpose  : Self-checking bench for screen_ctrl (DEBOUNCE_CYCLES=4,
//            PLOT_DELAY=2). A behavioural screen/menu model predicts every
//            output each cycle; directed scenarios add literal expectations,
//            followed by randomized button traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_screen_ctrl;

    localparam int DEB = 4;
    localparam int PD  = 2;

    logic       clk       = 1'b0;
    logic       resetn    = 1'b0;
    logic       key_next  = 1'b1;
    logic       key_back  = 1'b1;
    logic       draw_busy = 1'b0;
    logic [9:0] x_in      = '0;
    logic [9:0] y_in      = '0;
    logic [1:0] select_screen;
    logic       draw_go;
    logic       plot;
    logic [9:0] x_out;
    logic [9:0] y_out;
    logic       game_active;

    screen_ctrl #(.DEBOUNCE_CYCLES(DEB), .PLOT_DELAY(PD)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .key_next     (key_next),
        .key_back     (key_back),
        .draw_busy    (draw_busy),
        .x_in         (x_in),
        .y_in         (y_in),
        .select_screen(select_screen),
        .draw_go      (draw_go),
        .plot         (plot),
        .x_out        (x_out),
        .y_out        (y_out),
        .game_active  (game_active)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_go  = 0;
    int n_plot = 0;
    int prev_sel = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 launching, 1 waiting for drawer, 2 drawing, 3 shown, 4 game
    // pending/event codes: 0 none, 1 next, 2 back
    int m_scr, m_game, m_go, m_phase, m_pend;
    int m_ev_n, m_ev_b;
    int m_lvl[2];
    int m_rawq[$];   // raw key pairs seen at each edge, newest first
    int m_sq[$];     // synchronized samples seen by the debouncer, newest first
    int m_hq[$];     // {busy,y,x} seen at each edge, newest first

    function automatic void model_reset();
        m_scr = 0; m_game = 0; m_go = 0; m_phase = 0; m_pend = 0;
        m_ev_n = 0; m_ev_b = 0;
        m_lvl[0] = 1; m_lvl[1] = 1;
        m_rawq.delete(); m_sq.delete(); m_hq.delete();
        for (int i = 0; i < 3; i++) m_rawq.push_front(3);
        for (int i = 0; i < DEB; i++) m_sq.push_front(3);
    endfunction

    function automatic void model_step();
        int live, comb, all_diff;
        live = m_ev_b ? 2 : (m_ev_n ? 1 : 0);
        comb = (live == 2) ? 2 : (live == 1) ? ((m_pend == 2) ? 2 : 1) : m_pend;
        m_go = 0;
        if (m_phase == 0) begin
            m_go = 1; m_phase = 1; m_pend = comb;
        end else if (m_phase == 1) begin
            m_pend = comb;
            if (draw_busy) m_phase = 2;
        end else if (m_phase == 2) begin
            m_pend = comb;
            if (!draw_busy) m_phase = 3;
        end else if (m_phase == 3) begin
            m_pend = 0;
            if (comb == 2 && m_scr == 1) begin
                m_scr = 0; m_phase = 0;
            end else if (comb == 1 && m_scr == 0) begin
                m_scr = 1; m_phase = 0;
            end else if (comb == 1 && m_scr == 1) begin
                m_scr = 2; m_game = 1; m_phase = 4;
            end
        end else begin
            m_pend = 0;
            if (live == 2) begin
                m_scr = 0; m_game = 0; m_phase = 0;
            end
        end
        // pixel history
        m_hq.push_front((int'(draw_busy) << 20) | (int'(y_in) << 10) | int'(x_in));
        if (m_hq.size() > PD) void'(m_hq.pop_back());
        // keys: debouncer sees the raw value from two edges ago
        m_rawq.push_front((int'(key_back) << 1) | int'(key_next));
        if (m_rawq.size() > 3) void'(m_rawq.pop_back());
        m_sq.push_front(m_rawq[2]);
        if (m_sq.size() > DEB) void'(m_sq.pop_back());
        m_ev_n = 0; m_ev_b = 0;
        for (int k = 0; k < 2; k++) begin
            all_diff = 1;
            for (int j = 0; j < DEB; j++)
                if (((m_sq[j] >> k) & 1) == m_lvl[k]) all_diff = 0;
            if (all_diff == 1) begin
                m_lvl[k] = 1 - m_lvl[k];
                if (m_lvl[k] == 0) begin
                    if (k == 0) m_ev_n = 1; else m_ev_b = 1;
                end
            end
        end
    endfunction

    task automatic compare();
        int e_plot, e_x, e_y;
        e_plot = 0; e_x = 0; e_y = 0;
        if (m_hq.size() == PD) begin
            e_plot = ((m_hq[PD-1] >> 20) & 1) & (1 - m_game);
            e_x    = m_hq[PD-1] & 'h3ff;
            e_y    = (m_hq[PD-1] >> 10) & 'h3ff;
        end
        chk("select_screen", int'(select_screen), m_scr);
        chk("game_active", int'(game_active), m_game);
        chk("draw_go", int'(draw_go), m_go);
        chk("plot", int'(plot), e_plot);
        chk("x_out", int'(x_out), e_x);
        chk("y_out", int'(y_out), e_y);
        chk("sel_change_while_busy", int'(int'(select_screen) != prev_sel && draw_busy), 0);
        prev_sel = int'(select_screen);
        if (draw_go) n_go++;
        if (plot) n_plot++;
    endtask

    // ---------------- drawer stand-in ----------------
    int dr_cnt = 0, dr_left = 0, dr_pix = 0, draw_len = 40;

    task automatic drawer_abort();
        draw_busy = 1'b0; dr_cnt = 0; dr_left = 0; dr_pix = 0;
        x_in = '0; y_in = '0;
    endtask

    task automatic drawer_update();
        if (draw_busy) begin
            dr_pix++; dr_left--;
            if (dr_left <= 0) draw_busy = 1'b0;
        end else if (dr_cnt > 0) begin
            dr_cnt--;
            if (dr_cnt == 0) begin
                draw_busy = 1'b1; dr_left = draw_len; dr_pix = 0;
            end
        end
        if (draw_go) dr_cnt = 1;
        x_in = 10'(dr_pix % 160);
        y_in = 10'(dr_pix / 160);
    endtask

    task automatic tick();
        @(posedge clk);
        if (resetn) model_step(); else model_reset();
        @(negedge clk);
        compare();
        drawer_update();
    endtask

    task automatic press(input int mask, input int low, input int high);
        key_next = !(mask & 1);
        key_back = !(mask & 2);
        repeat (low) tick();
        key_next = 1'b1;
        key_back = 1'b1;
        repeat (high) tick();
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((draw_busy || dr_cnt > 0 || draw_go) && t < 30000) begin
            tick(); t++;
        end
        if (t >= 30000) begin
            n_vec++; n_err++;
            $display("FAIL wait_idle: drawer still busy after %0d cycles, expected idle", t);
        end
        repeat (6) tick();
    endtask

    task automatic async_reset_pulse();
        resetn = 1'b0;
        drawer_abort();
        model_reset();
        #1;
        compare();
        chk("rst_select", int'(select_screen), 0);
        chk("rst_draw_go", int'(draw_go), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_x_out", int'(x_out), 0);
        chk("rst_y_out", int'(y_out), 0);
        chk("rst_game", int'(game_active), 0);
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        int t;
        model_reset();
        repeat (3) tick();

        // Power-up title draw, full screen.
        draw_len = 19200; n_go = 0; n_plot = 0;
        resetn = 1'b1;
        tick();
        chk("first_edge_draw_go", int'(draw_go), 1);
        wait_idle();
        chk("title_go_count", n_go, 1);
        chk("title_plot_count", n_plot, 19200);
        chk("title_select", int'(select_screen), 0);

        // Short glitch is rejected, real press is taken.
        draw_len = 40; n_go = 0;
        press(1, 3, 10);
        chk("glitch_select", int'(select_screen), 0);
        chk("glitch_go_count", n_go, 0);
        press(1, 6, 8);
        chk("press_select", int'(select_screen), 1);
        chk("press_go_count", n_go, 1);
        wait_idle();

        // Back to title, then next pressed during the title draw.
        draw_len = 80;
        press(2, 6, 8);
        chk("back_select", int'(select_screen), 0);
        t = 0;
        while (!draw_busy && t < 100) begin tick(); t++; end
        chk("title_busy_seen", int'(draw_busy), 1);
        press(1, 6, 2);
        chk("held_next_select", int'(select_screen), 0);
        wait_idle();
        wait_idle();
        chk("held_next_applied", int'(select_screen), 1);

        // Into the game: no draw, plot suppressed even if busy toggles.
        n_go = 0; n_plot = 0;
        press(1, 6, 8);
        chk("game_select", int'(select_screen), 2);
        chk("game_active", int'(game_active), 1);
        draw_busy = 1'b1; dr_left = 5;
        repeat (8) tick();
        chk("game_go_count", n_go, 0);
        chk("game_plot_count", n_plot, 0);
        n_go = 0;
        press(2, 6, 8);
        chk("exit_select", int'(select_screen), 0);
        chk("exit_game_active", int'(game_active), 0);
        chk("exit_go_count", n_go, 1);
        wait_idle();

        // Simultaneous next + back on the instructions screen.
        press(1, 6, 8);
        wait_idle();
        chk("instr_select", int'(select_screen), 1);
        press(3, 6, 8);
        chk("both_select", int'(select_screen), 0);
        wait_idle();

        // Random button traffic.
        repeat (150) begin
            draw_len = $urandom_range(10, 50);
            press($urandom_range(1, 3), $urandom_range(1, 8), $urandom_range(1, 12));
        end
        wait_idle();
        wait_idle();

        // Reset mid-draw at pixel 5000.
        draw_len = 6000;
        async_reset_pulse();
        tick();
        chk("post_reset1_draw_go", int'(draw_go), 1);
        t = 0;
        while (dr_pix != 5000 && t < 10000) begin tick(); t++; end
        chk("reached_pixel_5000", dr_pix, 5000);
        async_reset_pulse();
        n_plot = 0;
        tick();
        chk("post_reset2_draw_go", int'(draw_go), 1);
        chk("post_reset2_plot", int'(plot), 0);
        tick();
        chk("no_stale_plot", n_plot, 0);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/screen_ctrl.md
SCREEN_CTRL -- requirements
Module: screen_ctrl

Interface
Parameters:
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000: number of consecutive stable clk cycles a key must hold before the level change is accepted (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter PLOT_DELAY, default 2, legal 1..4: clk cycles from draw address to valid colour in the memory stage.

Ports:
REQ-003 The block SHALL have clk, input, 1: single clock, all logic on rising edge.
REQ-004 The block SHALL have resetn, input, 1: asynchronous active-low reset.
REQ-005 The block SHALL have key_next, input, 1: raw active-low pushbutton, asynchronous to clk.
REQ-006 The block SHALL have key_back, input, 1: raw active-low pushbutton, asynchronous to clk.
REQ-007 The block SHALL have draw_busy, input, 1: draw-in-progress flag from the screen-memory drawer.
REQ-008 The block SHALL have x_in and y_in, input, 10 each: current draw coordinates from the drawer.
REQ-009 The block SHALL have select_screen, output, 2: 0 = title, 1 = instructions, 2 = game.
REQ-010 The block SHALL have draw_go, output, 1: one-cycle pulse that starts a full-screen memory draw.
REQ-011 The block SHALL have plot, output, 1: write enable to the VGA adapter.
REQ-012 The block SHALL have x_out and y_out, output, 10 each: coordinates aligned with plot.
REQ-013 The block SHALL have game_active, output, 1: high while the game screen owns the display.

Function
REQ-014 Each key SHALL pass through a 2-flop synchronizer, then a debounce counter; the accepted level changes only after DEBOUNCE_CYCLES identical synchronized samples, and any differing sample restarts the count.
REQ-015 The block SHALL generate a one-cycle press event when a key's accepted level goes 1->0; release generates no event.
REQ-016 If next and back events occur in the same cycle, back SHALL win and next SHALL be discarded.
REQ-017 The FSM SHALL have states LAUNCH, WAIT_START, DRAWING, SHOWN and GAME.
REQ-018 LAUNCH SHALL assert draw_go for exactly one cycle, then go to WAIT_START.
REQ-019 WAIT_START SHALL go to DRAWING when draw_busy=1; draw_go SHALL NOT be re-asserted.
REQ-020 DRAWING SHALL go to SHOWN on the first cycle draw_busy=0.
REQ-021 In SHOWN, a back event SHALL act as follows: screen 1 -> set select_screen=0 and go to LAUNCH; screen 0 -> ignored.
REQ-022 In SHOWN, a next event SHALL act as follows: screen 0 -> set select_screen=1 and go to LAUNCH; screen 1 -> set select_screen=2, game_active=1 and go to GAME.
REQ-023 In GAME, a back event SHALL set select_screen=0, clear game_active and go to LAUNCH; next SHALL be ignored.
REQ-024 Events arriving in LAUNCH, WAIT_START or DRAWING SHALL be held in a single pending slot; a later event overwrites it, except that back is never overwritten by next.
REQ-025 The pending slot SHALL be consumed and cleared on the first SHOWN cycle, with the same effect as a live event.
REQ-026 select_screen SHALL change only on the transition into LAUNCH or GAME, never while draw_busy=1.
REQ-027 plot SHALL equal draw_busy delayed by exactly PLOT_DELAY cycles, and x_out/y_out SHALL equal x_in/y_in delayed by the same amount through a shift pipeline.
REQ-028 plot SHALL be forced to 0 while game_active=1.
REQ-029 draw_go and plot SHALL never be driven from combinational paths on key inputs.

Reset
REQ-030 While resetn=0 (asynchronous), the outputs SHALL be select_screen=0, draw_go=0, plot=0, x_out=0, y_out=0, game_active=0.
REQ-031 While resetn=0, the pipeline, pending slot, synchronizers (to 1 = released) and debounce counters SHALL clear, and the FSM SHALL be in LAUNCH.
REQ-032 The first rising clk edge after resetn deasserts SHALL produce draw_go=1, so the title is redrawn automatically.
REQ-033 Reset asserted mid-draw SHALL abort immediately, with no further plot pulses from pre-reset pipeline contents.

Verification (DEBOUNCE_CYCLES=4, PLOT_DELAY=2)
REQ-034 A bench SHALL cover: release reset, drawer raises draw_busy 2 cycles later for 19200 cycles -> exactly one draw_go on cycle 1, plot high for 19200 cycles starting 2 cycles after draw_busy, state SHOWN, select_screen=0.
REQ-035 A bench SHALL cover: key_next low for 3 cycles then high -> no event, select_screen stays 0; key_next low for 6 cycles -> select_screen=1 and one draw_go.
REQ-036 A bench SHALL cover: next pressed during a title draw -> no action until draw_busy falls, then select_screen=1 and draw_go one cycle after SHOWN.
REQ-037 A bench SHALL cover: from screen 1, next -> select_screen=2, game_active=1, no draw_go, plot=0; then back -> select_screen=0, game_active=0, draw_go pulse.
REQ-038 A bench SHALL cover: next and back debounced in the same cycle on screen 1 -> select_screen=0.
REQ-039 A bench SHALL cover: resetn low at draw pixel 5000 for 1 cycle -> all outputs 0 the same cycle, plot stays 0 until the new draw, draw_go on the first edge after release.
